// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the single-port memory_control interface between a
// config writer (requester 0) and a display/miner reader (requester 1).
// Round-robin arbitration with one transaction in flight at a time.
// Optional ACCESS watchdog: define MEMORY_ARBITER_TIMEOUT_EN to enable it.
module memory_arbiter #(
   parameter int ADDRESS_WIDTH  = 9,
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     request_0,
   input  logic                     write_0,
   input  logic [ADDRESS_WIDTH-1:0] address_0,
   input  logic [DATA_WIDTH-1:0]    data_0,
   output logic                     grant_0,
   output logic                     done_0,
   output logic [DATA_WIDTH-1:0]    read_data_0,
   input  logic                     request_1,
   input  logic                     write_1,
   input  logic [ADDRESS_WIDTH-1:0] address_1,
   input  logic [DATA_WIDTH-1:0]    data_1,
   output logic                     grant_1,
   output logic                     done_1,
   output logic [DATA_WIDTH-1:0]    read_data_1,
   output logic                     mem_unlock,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]    mem_data,
   input  logic [DATA_WIDTH-1:0]    mem_buffer,
   input  logic                     mem_ready,
   output logic                     error
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state_reg;
   logic   owner_reg;         // requester being served by the current transaction
   logic   last_served_reg;   // resets to 1 so a tie straight after reset goes to requester 0
   logic   first_access_reg;  // mem_ready still reflects the previous access on this cycle

   logic   winner;
   logic   ready_hit;
   logic   timeout_hit;
   logic   complete;

   // A lone requester wins; on a tie the one not served last wins
   assign winner    = (request_0 && request_1) ? ~last_served_reg : request_1;
   assign ready_hit = (state_reg == ACCESS) && !first_access_reg && mem_ready;
   assign complete  = ready_hit || timeout_hit;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
   localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   logic [COUNT_WIDTH-1:0] count_reg;
   logic                   error_reg;

   // Watchdog fires at the end of the TIMEOUT_CYCLES-th ACCESS cycle unless memory answered
   assign timeout_hit = (state_reg == ACCESS) && !ready_hit &&
                        (count_reg == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
   assign error       = error_reg;
`else
   // Without the watchdog the limit is irrelevant and ACCESS waits for mem_ready forever
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES > 0);
   assign timeout_hit    = 1'b0;
   assign error          = 1'b0;
`endif

   // Sequencer: arbitrate in IDLE, hold the memory request in ACCESS, report in DONE
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= IDLE;
         owner_reg        <= 1'b0;
         last_served_reg  <= 1'b1;
         first_access_reg <= 1'b0;
         grant_0          <= 1'b0;
         grant_1          <= 1'b0;
         done_0           <= 1'b0;
         done_1           <= 1'b0;
         mem_unlock       <= 1'b0;
         mem_address      <= '0;
         mem_data         <= '0;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
         count_reg        <= '0;
         error_reg        <= 1'b0;
`endif
      end else begin
         done_0 <= 1'b0;
         done_1 <= 1'b0;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
         error_reg <= 1'b0;
`endif
         case (state_reg)
            IDLE: begin
               if (request_0 || request_1) begin
                  owner_reg        <= winner;
                  grant_0          <= ~winner;
                  grant_1          <= winner;
                  mem_unlock       <= winner ? write_1   : write_0;
                  mem_address      <= winner ? address_1 : address_0;
                  mem_data         <= winner ? data_1    : data_0;
                  first_access_reg <= 1'b1;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
                  count_reg        <= '0;
`endif
                  state_reg        <= ACCESS;
               end
            end
            ACCESS: begin
               first_access_reg <= 1'b0;
               if (complete) begin
                  done_0          <= ~owner_reg;
                  done_1          <= owner_reg;
                  last_served_reg <= owner_reg;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
                  error_reg       <= timeout_hit;
`endif
                  state_reg       <= DONE;
               end
`ifdef MEMORY_ARBITER_TIMEOUT_EN
               else begin
                  count_reg <= count_reg + COUNT_WIDTH'(1);
               end
`endif
            end
            DONE: begin
               grant_0    <= 1'b0;
               grant_1    <= 1'b0;
               mem_unlock <= 1'b0;
               state_reg  <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_read_data
         logic [DATA_WIDTH-1:0] value_reg;

         // Latch the memory word for the owner only on a genuine completion
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               value_reg <= '0;
            end else if (ready_hit && (owner_reg == 1'(gi))) begin
               value_reg <= mem_buffer;
            end
         end
      end
   endgenerate

   assign read_data_0 = g_read_data[0].value_reg;
   assign read_data_1 = g_read_data[1].value_reg;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level model of the arbiter.
module tb_memory_arbiter;

   localparam int AW = 9;
   localparam int DW = 16;
   localparam int TO = 8;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic [1:0]    req_v = '0;
   logic [1:0]    wr_v = '0;
   logic [AW-1:0] addr_v [2];
   logic [DW-1:0] wdat_v [2];
   logic [1:0]    grant_v;
   logic [1:0]    done_v;
   logic [DW-1:0] read_data_0, read_data_1;
   logic          mem_unlock;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] mem_buffer = '0;
   logic          mem_ready = 1'b0;
   logic          error;

   int checks = 0;
   int errors = 0;
   int txn_count = 0;

   memory_arbiter #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .request_0  (req_v[0]),
      .write_0    (wr_v[0]),
      .address_0  (addr_v[0]),
      .data_0     (wdat_v[0]),
      .grant_0    (grant_v[0]),
      .done_0     (done_v[0]),
      .read_data_0(read_data_0),
      .request_1  (req_v[1]),
      .write_1    (wr_v[1]),
      .address_1  (addr_v[1]),
      .data_1     (wdat_v[1]),
      .grant_1    (grant_v[1]),
      .done_1     (done_v[1]),
      .read_data_1(read_data_1),
      .mem_unlock (mem_unlock),
      .mem_address(mem_address),
      .mem_data   (mem_data),
      .mem_buffer (mem_buffer),
      .mem_ready  (mem_ready),
      .error      (error)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // m_age: number of ACCESS cycles the live transaction has spent (-1 = none live)
   int            m_age = -1;
   bit            m_done = 1'b0;
   bit            m_owner = 1'b0;
   bit            m_last = 1'b1;
   bit            m_write = 1'b0;
   bit            m_error = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;
   logic [DW-1:0] m_rd [2] = '{default: '0};

   always @(posedge clock or negedge reset_n) begin
      int n;
      if (!reset_n) begin
         m_age   = -1;
         m_done  = 1'b0;
         m_last  = 1'b1;
         m_error = 1'b0;
         m_write = 1'b0;
         m_rd[0] = '0;
         m_rd[1] = '0;
      end else if (m_done) begin
         m_done  = 1'b0;
         m_error = 1'b0;
      end else if (m_age < 0) begin
         if (req_v != 2'b00) begin
            m_owner = (req_v == 2'b11) ? ~m_last : req_v[1];
            m_write = wr_v[m_owner];
            m_addr  = addr_v[m_owner];
            m_wdata = wdat_v[m_owner];
            m_age   = 0;
         end
      end else begin
         n = m_age + 1;
         if (n >= 2 && mem_ready) begin
            m_rd[m_owner] = mem_buffer;
            m_done = 1'b1; m_age = -1; m_last = m_owner;
         end else if (TO_EN && n == TO) begin
            m_error = 1'b1;
            m_done = 1'b1; m_age = -1; m_last = m_owner;
         end else begin
            m_age = n;
         end
      end
   end

   // Compare DUT against the model every cycle, away from the active edge
   always @(negedge clock) begin
      bit active;
      active = (m_age >= 0) || m_done;
      check("grant_0", grant_v[0], active && !m_owner);
      check("grant_1", grant_v[1], active && m_owner);
      check("done_0", done_v[0], m_done && !m_owner);
      check("done_1", done_v[1], m_done && m_owner);
      check("mem_unlock", mem_unlock, active && m_write);
      check("error", error, m_done && m_error);
      check("read_data_0", read_data_0, m_rd[0]);
      check("read_data_1", read_data_1, m_rd[1]);
      if (active) begin
         check("mem_address", mem_address, m_addr);
         check("mem_data", mem_data, m_wdata);
      end
      if (m_done) begin
         txn_count++;
         $display("txn %0d: req%0d %s addr=%h wdata=%h rdata0=%h rdata1=%h timeout=%0d",
                  txn_count, m_owner, m_write ? "write" : "read", m_addr, m_wdata,
                  m_rd[0], m_rd[1], m_error);
      end
   end

   // ---------------- randomized requester / memory behaviour ----------------
   bit pend [2] = '{default: 1'b0};

   task automatic drive_random();
      mem_ready = ($urandom_range(0, 2) == 0);
      if (m_age < 0 && !m_done) mem_buffer = DW'($urandom);
      for (int i = 0; i < 2; i++) begin
         if (!pend[i]) begin
            if ($urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1; req_v[i] = 1'b1; wr_v[i] = 1'($urandom_range(0, 1));
               addr_v[i] = AW'($urandom); wdat_v[i] = DW'($urandom);
            end
         end else if (done_v[i]) begin
            if ($urandom_range(0, 1) == 0) begin
               req_v[i] = 1'b1; wr_v[i] = 1'($urandom_range(0, 1));
               addr_v[i] = AW'($urandom); wdat_v[i] = DW'($urandom);
            end else begin
               pend[i] = 1'b0; req_v[i] = 1'b0;
            end
         end else if (grant_v[i] && $urandom_range(0, 7) == 0) begin
            req_v[i] = 1'b0;
         end
      end
   endtask

   initial begin
      int order [$];
      bit prev0, prev1;
      addr_v = '{default: '0};
      wdat_v = '{default: '0};

      // Reset state
      repeat (3) @(negedge clock);
      check("rst grant_0", grant_v[0], 0);
      check("rst grant_1", grant_v[1], 0);
      check("rst mem_unlock", mem_unlock, 0);
      check("rst read_data_0", read_data_0, 0);
      check("rst error", error, 0);
      reset_n = 1'b1;
      @(negedge clock);

      // Single write with mem_ready held high: done exactly in cycle N+3
      req_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 9'h005; wdat_v[0] = 16'hBEEF;
      mem_buffer = 16'hCAFE; mem_ready = 1'b1;
      @(negedge clock);
      check("wr grant_0 N+1", grant_v[0], 1);
      check("wr unlock N+1", mem_unlock, 1);
      check("wr address", mem_address, 9'h005);
      check("wr data", mem_data, 16'hBEEF);
      check("stale done_0 N+1", done_v[0], 0);
      @(negedge clock);
      check("stale done_0 N+2", done_v[0], 0);
      @(negedge clock);
      check("wr done_0 N+3", done_v[0], 1);
      check("wr unlock N+3", mem_unlock, 1);
      check("wr read_data_0", read_data_0, 16'hCAFE);
      req_v[0] = 1'b0;
      @(negedge clock);
      check("wr grant_0 after", grant_v[0], 0);
      check("wr unlock after", mem_unlock, 0);

      // Single read by requester 1, ready arriving a cycle later
      req_v[1] = 1'b1; wr_v[1] = 1'b0; addr_v[1] = 9'h000; wdat_v[1] = 16'h5555;
      mem_buffer = 16'h1234; mem_ready = 1'b0;
      @(negedge clock);
      check("rd grant_1", grant_v[1], 1);
      check("rd unlock", mem_unlock, 0);
      mem_ready = 1'b1;
      repeat (2) @(negedge clock);
      check("rd done_1", done_v[1], 1);
      check("rd read_data_1", read_data_1, 16'h1234);
      check("rd read_data_0 kept", read_data_0, 16'hCAFE);
      req_v[1] = 1'b0; mem_ready = 1'b0;
      @(negedge clock);

      // Reset in the middle of ACCESS
      req_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 9'h1A0; wdat_v[0] = 16'h0F0F;
      repeat (2) @(negedge clock);
      check("abort grant_0 before", grant_v[0], 1);
      #2 reset_n = 1'b0;
      #1;
      check("abort grant_0", grant_v[0], 0);
      check("abort unlock", mem_unlock, 0);
      check("abort done_0", done_v[0], 0);
      check("abort error", error, 0);
      check("abort read_data_1", read_data_1, 0);

      // Fairness: both requesting from reset release, ready always high
      req_v[1] = 1'b1; wr_v[1] = 1'b0; addr_v[1] = 9'h0AA;
      mem_buffer = 16'h7777; mem_ready = 1'b1;
      @(negedge clock);
      reset_n = 1'b1;
      prev0 = 1'b0; prev1 = 1'b0;
      for (int c = 0; c < 60 && order.size() < 4; c++) begin
         @(negedge clock);
         check("fair exclusive grants", grant_v[0] & grant_v[1], 0);
         if (grant_v[0] && !prev0) order.push_back(0);
         if (grant_v[1] && !prev1) order.push_back(1);
         prev0 = grant_v[0]; prev1 = grant_v[1];
      end
      check("fair grant count", order.size(), 4);
      for (int k = 0; k < order.size(); k++)
         check($sformatf("fair order %0d", k), order[k], k % 2);
      req_v = 2'b00; mem_ready = 1'b0;
      repeat (5) @(negedge clock);

`ifdef MEMORY_ARBITER_TIMEOUT_EN
      // Watchdog: no mem_ready, done+error after TO ACCESS cycles, read data untouched
      req_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 9'h003; mem_buffer = 16'h9999;
      for (int k = 1; k <= TO; k++) begin
         @(negedge clock);
         check($sformatf("to done_0 N+%0d", k), done_v[0], 0);
      end
      @(negedge clock);
      check("to done_0", done_v[0], 1);
      check("to error", error, 1);
      check("to read_data_0 kept", read_data_0, 16'h7777);
      mem_ready = 1'b1;
      repeat (4) @(negedge clock);
      check("to next done_0", done_v[0], 1);
      check("to next error", error, 0);
      check("to next read_data_0", read_data_0, 16'h9999);
      req_v[0] = 1'b0; mem_ready = 1'b0;
      repeat (2) @(negedge clock);
`endif

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         drive_random();
      end
      req_v = 2'b00;
      repeat (20) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
